// File: rtl/avalon_st_pkt_arbiter_pkg.sv
// avalon_arb_pkg: shared types and helpers for the Avalon-ST packet arbiter.
//   arb_state_t  - arbiter FSM states
//   idx_width    - width of an index into n requesters (never below 1)
//   empty_width  - width of the Avalon-ST empty field for a bus of n bytes
//   rr_next      - scalar round-robin pick over up to 16 requesters:
//                  returns {found, idx}, searching last+1, last+2, ... mod n
package avalon_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int empty_width(input int n_bytes);
        return (n_bytes > 1) ? $clog2(n_bytes) : 1;
    endfunction

    function automatic logic [4:0] rr_next(input logic [15:0] req,
                                           input logic [3:0]  last,
                                           input int          n);
        logic [4:0] res;
        res = '0;
        for (int k = 1; k <= 16; k++) begin
            int j;
            j = (int'(last) + k) % n;
            if (k <= n && !res[4] && req[j]) begin
                res = {1'b1, 4'(j)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/avalon_st_pkt_arbiter_if.sv
// avalon_st_if: one Avalon-ST stream.
//   master - drives data/valid/sop/eop/empty, receives rdy
//   slave  - receives data/valid/sop/eop/empty, drives rdy
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 16
);
    localparam int EW = avalon_arb_pkg::empty_width(DATA_WIDTH_IN_BYTES);

    logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
    logic                             valid;
    logic                             sop;
    logic                             eop;
    logic [EW-1:0]                    empty;
    logic                             rdy;

    modport master (output data, valid, sop, eop, empty, input rdy);
    modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_st_pkt_arbiter_rr_priority_picker.sv
// rr_priority_picker: combinational round-robin find-first.
//   req   - request bit per requester
//   last  - index granted most recently (lowest priority this round)
//   found - at least one request present
//   idx   - first requester after last, wrapping modulo N
// Rotates req so that bit last+1 lands at position 0, finds the lowest set
// bit, then adds the rotation back to get the absolute index.
module rr_priority_picker
    import avalon_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]              req,
    input  logic [idx_width(N)-1:0]   last,
    output logic                      found,
    output logic [idx_width(N)-1:0]   idx
);
    localparam int IW = idx_width(N);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    int             first;

    always_comb begin
        req_dbl = {req, req};
        // last <= N-1, so the shift is at most N and stays inside req_dbl
        req_rot = N'(req_dbl >> (int'(last) + 1));
        found   = |req_rot;
        first   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                first = k;
            end
        end
        idx = IW'((int'(last) + 1 + first) % N);
    end
endmodule

// File: rtl/avalon_st_pkt_arbiter.sv
// avalon_st_pkt_arbiter: packet-level round-robin merge of NUM_INPUTS
// Avalon-ST streams onto one output. A grant lives from SOP to EOP so
// packets never interleave. The datapath is purely combinational.
//
// Ports:
//   clk              - system clock
//   rst              - asynchronous active-low reset
//   in_msg[]         - requester streams (slave side)
//   out_msg          - merged stream (master side)
//   grant_idx        - input currently owning the output
//   busy             - a multi-beat packet holds the grant
//   orphan_drop_indi - a non-granted input's non-SOP beat was discarded
//   watchdog_indi    - grant forcibly released after a stall
//
// Optional build macro AVALON_ARB_WATCHDOG_EN: when defined, a stalled grant
// is released after WATCHDOG_CYCLES cycles without a transfer; otherwise
// watchdog_indi is constant 0 and a grant is held indefinitely.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no packet open; SOP candidates arbitrated round-robin each cycle
// BUSY  | packet open on grant_idx; pass-through until its EOP transfers
module avalon_st_pkt_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int NUM_INPUTS          = 4,
    parameter int WATCHDOG_CYCLES     = 256
) (
    input  logic                               clk,
    input  logic                               rst,
    avalon_st_if.slave                         in_msg [NUM_INPUTS],
    avalon_st_if.master                        out_msg,
    output logic [idx_width(NUM_INPUTS)-1:0]   grant_idx,
    output logic                               busy,
    output logic                               orphan_drop_indi,
    output logic                               watchdog_indi
);
    localparam int IW = idx_width(NUM_INPUTS);
    localparam int DW = 8 * DATA_WIDTH_IN_BYTES;
    localparam int EW = empty_width(DATA_WIDTH_IN_BYTES);

    logic [NUM_INPUTS-1:0] in_valid;
    logic [NUM_INPUTS-1:0] in_sop;
    logic [NUM_INPUTS-1:0] in_eop;
    logic [NUM_INPUTS-1:0] in_rdy;
    logic [NUM_INPUTS-1:0] req;
    logic [DW-1:0]         in_data  [NUM_INPUTS];
    logic [EW-1:0]         in_empty [NUM_INPUTS];

    arb_state_t            state;
    logic [IW-1:0]         last_grant;
    logic [IW-1:0]         grant_reg;
    logic [IW-1:0]         pick_idx;
    logic [IW-1:0]         sel_idx;
    logic                  pick_found;
    logic                  sel_active;
    logic                  sel_eop;
    logic                  out_valid;
    logic                  xfer;
    logic                  orphan;
    logic                  wd_fire;

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_port
        assign in_valid[g]  = in_msg[g].valid;
        assign in_sop[g]    = in_msg[g].sop;
        assign in_eop[g]    = in_msg[g].eop;
        assign in_data[g]   = in_msg[g].data;
        assign in_empty[g]  = in_msg[g].empty;
        assign in_msg[g].rdy = in_rdy[g];
    end

    assign req = in_valid & in_sop;

    rr_priority_picker #(
        .N (NUM_INPUTS)
    ) u_picker (
        .req   (req),
        .last  (last_grant),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // rst gates every combinational output so reset silences the port at once
    always_comb begin
        sel_idx    = (state == BUSY) ? grant_reg : pick_idx;
        sel_active = rst && ((state == BUSY) || pick_found);
        out_valid  = sel_active && in_valid[sel_idx];
        sel_eop    = in_eop[sel_idx];
        xfer       = out_valid && out_msg.rdy;
        orphan     = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            in_rdy[i] = 1'b0;
            if (sel_active && (IW'(i) == sel_idx)) begin
                in_rdy[i] = out_msg.rdy;
            end else if (rst && in_valid[i] && !in_sop[i]) begin
                // mid-packet beat with no open grant: drain it
                in_rdy[i] = 1'b1;
                orphan    = 1'b1;
            end
        end
    end

    assign out_msg.valid    = out_valid;
    assign out_msg.data     = in_data[sel_idx];
    assign out_msg.sop      = in_sop[sel_idx];
    assign out_msg.eop      = sel_eop;
    assign out_msg.empty    = in_empty[sel_idx];
    assign grant_idx        = (rst && (state == IDLE) && pick_found) ? pick_idx : grant_reg;
    assign busy             = (state == BUSY);
    assign orphan_drop_indi = orphan;
    assign watchdog_indi    = wd_fire;

`ifdef AVALON_ARB_WATCHDOG_EN
    localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [WW-1:0] WD_LOAD = WW'(WATCHDOG_CYCLES - 1);

    logic [WW-1:0] wd_cnt;

    // down-counter reaches zero on the last permitted stall cycle
    assign wd_fire = (state == BUSY) && !xfer && (wd_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= WD_LOAD;
        end else if ((state != BUSY) || xfer || wd_fire) begin
            wd_cnt <= WD_LOAD;
        end else begin
            wd_cnt <= wd_cnt - 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= IW'(NUM_INPUTS - 1);
            grant_reg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        last_grant <= pick_idx;
                        grant_reg  <= pick_idx;
                        if (!sel_eop) begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (xfer && sel_eop) begin
                        state <= IDLE;
                    end else if (wd_fire) begin
                        state      <= IDLE;
                        last_grant <= grant_reg;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_avalon_st_pkt_arbiter.sv
`timescale 1ns/1ps
module tb_avalon_st_pkt_arbiter;
    import avalon_arb_pkg::*;

    localparam int DWB = 4;
    localparam int NI  = 4;
    localparam int DW  = 8 * DWB;
    localparam int EW  = empty_width(DWB);
    localparam int IW  = idx_width(NI);
`ifdef AVALON_ARB_WATCHDOG_EN
    localparam int WDC = 8;
`else
    localparam int WDC = 0;
`endif
    localparam int WDC_P = (WDC > 0) ? WDC : 256;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NI-1:0] drv_valid, drv_sop, drv_eop, obs_rdy;
    logic [DW-1:0] drv_data  [NI];
    logic [EW-1:0] drv_empty [NI];
    logic          drv_out_rdy;
    logic [IW-1:0] grant_idx;
    logic          busy, orphan_drop_indi, watchdog_indi;

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(DWB)) in_if [NI] ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(DWB)) out_if ();

    for (genvar g = 0; g < NI; g++) begin : g_drv
        assign in_if[g].valid = drv_valid[g];
        assign in_if[g].sop   = drv_sop[g];
        assign in_if[g].eop   = drv_eop[g];
        assign in_if[g].data  = drv_data[g];
        assign in_if[g].empty = drv_empty[g];
        assign obs_rdy[g]     = in_if[g].rdy;
    end
    assign out_if.rdy = drv_out_rdy;

    avalon_st_pkt_arbiter #(
        .DATA_WIDTH_IN_BYTES (DWB),
        .NUM_INPUTS          (NI),
        .WATCHDOG_CYCLES     (WDC_P)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_msg           (in_if),
        .out_msg          (out_if),
        .grant_idx        (grant_idx),
        .busy             (busy),
        .orphan_drop_indi (orphan_drop_indi),
        .watchdog_indi    (watchdog_indi)
    );

    // source queues and reference model state
    beat_t srcq [NI][$];
    int    owner;      // -1: no open packet, else the input holding the output
    int    last;       // most recently granted input
    int    ghold;      // grant index shown when nothing is selected
    int    stall;      // consecutive no-transfer cycles while a packet is open
    bit    in_rst;
    int    errors, checks;
    int    order_log[$];
    int    orphan_seen, wd_seen;

    int exp_contend[5] = '{0, 1, 2, 3, 0};
    int exp_single[8]  = '{1, 2, 1, 2, 1, 2, 1, 2};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rst(input logic v);
        rst = v;
        if (!v) begin
            in_rst = 1'b1;
            owner  = -1;
            last   = NI - 1;
            ghold  = 0;
            stall  = 0;
        end else begin
            in_rst = 1'b0;
        end
    endtask

    task automatic push_pkt(input int i, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data  = DW'($urandom);
            b.sop   = (k == 0);
            b.eop   = (k == len - 1);
            b.empty = (k == len - 1) ? EW'($urandom_range(DWB - 1)) : '0;
            srcq[i].push_back(b);
        end
    endtask

    task automatic push_beat(input int i, input logic s, input logic e);
        beat_t b;
        b.data  = DW'($urandom);
        b.sop   = s;
        b.eop   = e;
        b.empty = '0;
        srcq[i].push_back(b);
    endtask

    function automatic int qtotal();
        int t;
        t = 0;
        for (int i = 0; i < NI; i++) t += srcq[i].size();
        return t;
    endfunction

    task automatic drive(input int gap_pct);
        for (int i = 0; i < NI; i++) begin
            if (srcq[i].size() > 0 && $urandom_range(99) >= gap_pct) begin
                drv_valid[i] = 1'b1;
                drv_sop[i]   = srcq[i][0].sop;
                drv_eop[i]   = srcq[i][0].eop;
                drv_data[i]  = srcq[i][0].data;
                drv_empty[i] = srcq[i][0].empty;
            end else begin
                drv_valid[i] = 1'b0;
                drv_sop[i]   = 1'($urandom_range(1));
                drv_eop[i]   = 1'($urandom_range(1));
                drv_data[i]  = DW'($urandom);
                drv_empty[i] = '0;
            end
        end
    endtask

    // one clock: drive after the falling edge, check, advance model on the rising edge
    task automatic cyc(input string tag, input int rdy_mode, input int gap_pct);
        int          win, sel, eg;
        bit          ev, xfer, eorph, ewd;
        logic [NI-1:0] er;
        beat_t       hb;
        drv_out_rdy = (rdy_mode == 2) ? ($urandom_range(99) < 70) : (rdy_mode != 0);
        drive(gap_pct);
        #1;
        win = -1; sel = -1; ev = 0; er = '0; eorph = 0; ewd = 0;
        if (!in_rst) begin
            if (owner < 0) begin
                for (int k = 1; k <= NI; k++) begin
                    int j;
                    j = (last + k) % NI;
                    if (win < 0 && drv_valid[j] && drv_sop[j]) win = j;
                end
                sel = win;
            end else begin
                sel = owner;
            end
            ev = (sel >= 0) && drv_valid[sel];
            for (int i = 0; i < NI; i++) begin
                if (i == sel) er[i] = drv_out_rdy;
                else if (drv_valid[i] && !drv_sop[i]) begin
                    er[i] = 1'b1;
                    eorph = 1;
                end
            end
        end
        xfer = ev && drv_out_rdy;
        if (!in_rst && WDC > 0 && owner >= 0 && !xfer && stall == WDC - 1) ewd = 1;
        eg = in_rst ? 0 : ((sel >= 0) ? sel : ghold);

        chk({tag, " valid"}, 64'(out_if.valid), 64'(ev));
        if (ev) begin
            hb = srcq[sel][0];
            chk({tag, " data"},  64'(out_if.data),  64'(hb.data));
            chk({tag, " sop"},   64'(out_if.sop),   64'(hb.sop));
            chk({tag, " eop"},   64'(out_if.eop),   64'(hb.eop));
            chk({tag, " empty"}, 64'(out_if.empty), 64'(hb.empty));
        end
        chk({tag, " grant"},    64'(grant_idx),        64'(eg));
        chk({tag, " busy"},     64'(busy),             64'(!in_rst && owner >= 0));
        chk({tag, " rdy"},      64'(obs_rdy),          64'(er));
        chk({tag, " orphan"},   64'(orphan_drop_indi), 64'(eorph));
        chk({tag, " watchdog"}, 64'(watchdog_indi),    64'(ewd));

        if (out_if.valid && out_if.sop && drv_out_rdy) order_log.push_back(int'(grant_idx));
        if (orphan_drop_indi) orphan_seen++;
        if (watchdog_indi) wd_seen++;

        @(posedge clk);
        if (!in_rst) begin
            for (int i = 0; i < NI; i++) begin
                if (er[i] && drv_valid[i]) void'(srcq[i].pop_front());
            end
            if (owner < 0) begin
                if (xfer) begin
                    last  = win;
                    ghold = win;
                    if (!drv_eop[win]) begin
                        owner = win;
                        stall = 0;
                    end
                end
            end else if (xfer) begin
                stall = 0;
                if (drv_eop[owner]) owner = -1;
            end else if (WDC > 0) begin
                stall++;
                if (stall == WDC) begin
                    owner = -1;
                    last  = ghold;
                    stall = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input string tag, input int n, input int rdy_mode, input int gap_pct);
        for (int k = 0; k < n; k++) cyc(tag, rdy_mode, gap_pct);
    endtask

    task automatic run_drain(input string tag, input int rdy_mode, input int gap_pct, input int budget);
        int n;
        n = 0;
        while (qtotal() > 0 && n < budget) begin
            cyc(tag, rdy_mode, gap_pct);
            n++;
        end
        chk({tag, " drained"}, 64'(qtotal()), 64'(0));
    endtask

    initial begin
        errors = 0; checks = 0; orphan_seen = 0; wd_seen = 0;
        drv_valid = '0; drv_sop = '0; drv_eop = '0; drv_out_rdy = 1'b1;
        for (int i = 0; i < NI; i++) begin
            drv_data[i]  = '0;
            drv_empty[i] = '0;
        end
        set_rst(1'b0);

        // contention queued while in reset: outputs must stay silent
        push_pkt(0, 2); push_pkt(0, 2);
        push_pkt(1, 2); push_pkt(2, 2); push_pkt(3, 2);
        @(negedge clk);
        run("reset", 2, 1, 0);
        set_rst(1'b1);
        run_drain("contend", 1, 0, 100);
        chk("contend order count", 64'(order_log.size()), 64'(5));
        for (int k = 0; k < 5 && k < order_log.size(); k++)
            chk("contend order", 64'(order_log[k]), 64'(exp_contend[k]));

        // single input 3-beat packet
        order_log.delete();
        push_pkt(0, 3);
        run_drain("single", 1, 0, 20);
        chk("single grant", 64'(order_log.size() > 0 ? order_log[0] : -1), 64'(0));

        // single-beat packets alternate between in1 and in2
        order_log.delete();
        for (int k = 0; k < 4; k++) begin
            push_pkt(1, 1);
            push_pkt(2, 1);
        end
        run_drain("onebeat", 1, 0, 30);
        chk("onebeat order count", 64'(order_log.size()), 64'(8));
        for (int k = 0; k < 8 && k < order_log.size(); k++)
            chk("onebeat order", 64'(order_log[k]), 64'(exp_single[k]));

        // backpressure mid-packet
        push_pkt(2, 4);
        run("bp head", 2, 1, 0);
        run("bp stall", 5, 0, 0);
        run_drain("bp resume", 1, 0, 20);

        // orphan beat while idle
        orphan_seen = 0;
        push_beat(3, 1'b0, 1'b1);
        run("orphan", 2, 1, 0);
        chk("orphan pulses", 64'(orphan_seen), 64'(1));

`ifdef AVALON_ARB_WATCHDOG_EN
        wd_seen = 0;
        order_log.delete();
        push_beat(0, 1'b1, 1'b0);
        run("wd sop", 1, 1, 0);
        push_pkt(1, 1);
        run("wd stall", WDC + 1, 1, 0);
        chk("wd pulses", 64'(wd_seen), 64'(1));
        chk("wd next grant", 64'(order_log.size() > 1 ? order_log[1] : -1), 64'(1));
`endif

        // reset mid-packet; the leftover beats then drain as orphans
        orphan_seen = 0;
        push_pkt(2, 4);
        run("pre rst", 2, 1, 0);
        set_rst(1'b0);
        run("mid rst", 1, 1, 0);
        set_rst(1'b1);
        run_drain("post rst", 1, 0, 20);
        chk("post rst orphans", 64'(orphan_seen), 64'(2));

        // randomized traffic
        for (int k = 0; k < 40; k++) push_pkt($urandom_range(NI - 1), $urandom_range(1, 4));
        run_drain("random", 2, 20, 3000);
        run("tail", 3, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
